// File: rtl/fsm_down_counter_if.sv
// Control/status bundle for the modulo-MOD down-counter.
// master drives the enable/load side; slave is the counter itself.
interface fsm_down_counter_if #(
  parameter int WIDTH = 3
) ();
  logic             w;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             borrow;
  logic             load_err;

  modport master (
    output w, load, d,
    input  y, zero, borrow, load_err
  );

  modport slave (
    input  w, load, d,
    output y, zero, borrow, load_err
  );
endinterface

// File: rtl/fsm_down_counter.sv
// Modulo-MOD down-counter FSM with enable, synchronous parallel load,
// zero decode, one-cycle borrow pulse on wrap and a sticky load range error.
// The state is the count itself: S0..S(MOD-1) map directly onto y.
// Legal parameterisation: 2 <= MOD <= 2**WIDTH.
module fsm_down_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  fsm_down_counter_if.slave  bus
);

  typedef logic [WIDTH-1:0] state_t;

  // Wrap target and reset value.
  localparam state_t     TOP = state_t'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is still representable.
  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MOD);

  state_t y_q;
  logic   borrow_q;
  logic   err_q;
  logic   d_oob;

  // A load value at or above MOD would put the counter into an unreachable code.
  assign d_oob = ({1'b0, bus.d} >= LIM);

  // Counter state, borrow pulse and sticky error; load has priority over w.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q      <= TOP;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.load) begin
      borrow_q <= 1'b0;
      if (d_oob) begin
        y_q   <= TOP;
        err_q <= 1'b1;
      end else begin
        y_q <= bus.d;
      end
    end else if (bus.w) begin
      borrow_q <= (y_q == '0);
      y_q      <= (y_q == '0) ? TOP : (y_q - state_t'(1));
    end else begin
      borrow_q <= 1'b0;
    end
  end

  // Zero decodes only the registered count, never the inputs.
  assign bus.zero     = (y_q == '0);
  assign bus.y        = y_q;
  assign bus.borrow   = borrow_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_fsm_down_counter.sv
// Directed bench: MOD=8 and MOD=6 instances share clock and reset.
module tb_fsm_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_run = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fsm_down_counter_if #(.WIDTH(3)) b8 ();
  fsm_down_counter_if #(.WIDTH(3)) b6 ();

  fsm_down_counter #(.WIDTH(3), .MOD(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  fsm_down_counter #(.WIDTH(3), .MOD(6)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st8(input string tag, input int y, input int z, input int b, input int e);
    chk({tag, ".y"},   int'(b8.y), y);
    chk({tag, ".z"},   int'(b8.zero), z);
    chk({tag, ".b"},   int'(b8.borrow), b);
    chk({tag, ".err"}, int'(b8.load_err), e);
  endtask

  task automatic st6(input string tag, input int y, input int z, input int b, input int e);
    chk({tag, ".y"},   int'(b6.y), y);
    chk({tag, ".z"},   int'(b6.zero), z);
    chk({tag, ".b"},   int'(b6.borrow), b);
    chk({tag, ".err"}, int'(b6.load_err), e);
  endtask

  int ex1 [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
  int ex4 [6] = '{4, 3, 2, 1, 0, 5};
  int wv2 [4] = '{1, 0, 1, 0};
  int ex2 [4] = '{6, 6, 5, 5};

  initial begin
    b8.w = 0; b8.load = 0; b8.d = '0;
    b6.w = 0; b6.load = 0; b6.d = '0;

    // Reset state
    #12;
    st8("rst8", 7, 0, 0, 0);
    st6("rst6", 5, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    tick();
    st8("idle8", 7, 0, 0, 0);

    // 1: free count with wrap
    b8.w = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      st8($sformatf("t1_%0d", i), ex1[i], (ex1[i] == 0) ? 1 : 0, (i == 7) ? 1 : 0, 0);
    end

    // 2: load to 7 (no borrow), then alternating enable
    b8.w = 0; b8.load = 1; b8.d = 3'd7;
    tick();
    st8("t2_ld7", 7, 0, 0, 0);
    b8.load = 0;
    for (int i = 0; i < 4; i++) begin
      b8.w = wv2[i][0];
      tick();
      st8($sformatf("t2_%0d", i), ex2[i], 0, 0, 0);
    end

    // 3: load beats decrement
    b8.w = 0; b8.load = 1; b8.d = 3'd5;
    tick();
    chk("t3_y5", int'(b8.y), 5);
    b8.w = 1; b8.d = 3'd3;
    tick();
    st8("t3_ldw", 3, 0, 0, 0);

    // 6: load 0 beats wrap
    b8.w = 0; b8.d = 3'd0;
    tick();
    st8("t6_y0", 0, 1, 0, 0);
    b8.w = 1;
    tick();
    st8("t6_ldw", 0, 1, 0, 0);
    b8.load = 0; b8.w = 0;

    // 4: MOD=6 clamp, error, wrap
    b6.load = 1; b6.d = 3'd7;
    tick();
    st6("t4_clamp", 5, 0, 0, 1);
    b6.load = 0; b6.w = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      st6($sformatf("t4_%0d", i), ex4[i], (ex4[i] == 0) ? 1 : 0, (i == 5) ? 1 : 0, 1);
    end
    b6.w = 0; b6.load = 1; b6.d = 3'd2;
    tick();
    st6("t4_ld2", 2, 0, 0, 1);
    b6.d = 3'd6;
    tick();
    st6("t4_ld6", 5, 0, 0, 1);
    b6.load = 0;

    // 5: async reset with clock stopped, borrow pending
    chk("t5_pre", int'(b8.y), 0);
    b8.w = 1;
    tick();
    st8("t5_wrap", 7, 0, 1, 0);
    b8.w = 0; b8.load = 1; b8.d = 3'd3;
    tick();
    b8.load = 0; b8.w = 1;
    tick();
    chk("t5_y2", int'(b8.y), 2);
    b8.w = 0; b8.load = 1; b8.d = 3'd0;
    tick();
    b8.load = 0; b8.w = 1;
    tick();
    chk("t5_bpend", int'(b8.borrow), 1);
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    st8("t5_rst8", 7, 0, 0, 0);
    st6("t5_rst6", 5, 0, 0, 0);
    #3;
    rst = 1'b1;
    b8.w = 1;
    #2;
    clk_run = 1'b1;
    tick();
    st8("t5_rel", 6, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
